// File: rtl/decode_writeback_if.sv
// decode_writeback_if: fetch/execute-facing bundle of the decode/writeback register-file stage
interface decode_writeback_if #(
    parameter int DATA_WIDTH = 64
);
    logic [3:0]            icode;
    logic [3:0]            rA;
    logic [3:0]            rB;
    logic                  cnd;
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] valE;
    logic [DATA_WIDTH-1:0] valM;
    logic [3:0]            srcA;
    logic [3:0]            srcB;
    logic [3:0]            dstE;
    logic [3:0]            dstM;
    logic [DATA_WIDTH-1:0] valA;
    logic [DATA_WIDTH-1:0] valB;

    modport master (
        output icode, rA, rB, cnd, wb_en, valE, valM,
        input  srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  icode, rA, rB, cnd, wb_en, valE, valM,
        output srcA, srcB, dstE, dstM, valA, valB
    );
endinterface

// File: rtl/decode_writeback.sv
// decode_writeback: Y86 register-ID decode, zero-latency operand read and E/M writeback into the register file
module decode_writeback #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    NUM_REGS   = 15,
    parameter logic [3:0]            RSP_ID     = 4'd4,
    parameter logic [DATA_WIDTH-1:0] RSP_RESET  = '0
) (
    input logic               clk,
    input logic               rst_n,
    decode_writeback_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [3:0]            w_src_a;
    logic [3:0]            w_src_b;
    logic [3:0]            w_dst_e;
    logic [3:0]            w_dst_m;
    logic [DATA_WIDTH-1:0] w_val_a;
    logic [DATA_WIDTH-1:0] w_val_b;

    // Register IDs per instruction; cmov only claims its E destination when the condition holds
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (bus.icode)
            4'h2: begin
                w_src_a = bus.rA;
                w_dst_e = bus.cnd ? bus.rB : RNONE;
            end
            4'h3: w_dst_e = bus.rB;
            4'h4: begin
                w_src_a = bus.rA;
                w_src_b = bus.rB;
            end
            4'h5: begin
                w_src_b = bus.rB;
                w_dst_m = bus.rA;
            end
            4'h6: begin
                w_src_a = bus.rA;
                w_src_b = bus.rB;
                w_dst_e = bus.rB;
            end
            4'h8: begin
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'h9: begin
                w_src_a = RSP_ID;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'hA: begin
                w_src_a = bus.rA;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
            end
            4'hB: begin
                w_src_a = RSP_ID;
                w_src_b = RSP_ID;
                w_dst_e = RSP_ID;
                w_dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    // Zero-latency read ports; ID F never matches an entry so it reads as 0
    always_comb begin
        w_val_a = '0;
        w_val_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_src_a == 4'(i)) w_val_a = r_regs[i];
            if (w_src_b == 4'(i)) w_val_b = r_regs[i];
        end
    end

    // Commit E/M results; M is checked first so popq %rsp keeps the popped value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (4'(i) == RSP_ID) ? RSP_RESET : '0;
        end else if (bus.wb_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_dst_m == 4'(i))
                    r_regs[i] <= bus.valM;
                else if (w_dst_e == 4'(i))
                    r_regs[i] <= bus.valE;
            end
        end
    end

    assign bus.srcA = w_src_a;
    assign bus.srcB = w_src_b;
    assign bus.dstE = w_dst_e;
    assign bus.dstM = w_dst_m;
    assign bus.valA = w_val_a;
    assign bus.valB = w_val_b;
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed vectors with a queue-based scoreboard checked on the falling edge
module tb_decode_writeback;
    typedef struct packed {
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [63:0] va;
        logic [63:0] vb;
    } exp_t;

    logic   clk;
    logic   rst_n;
    int     errors;
    int     checks;
    exp_t   exp_q [$];
    string  name_q [$];

    decode_writeback_if #(.DATA_WIDTH(64)) bus ();

    decode_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_now(input string nm, input logic [3:0] xsa, input logic [3:0] xsb,
                              input logic [3:0] xde, input logic [3:0] xdm,
                              input logic [63:0] xva, input logic [63:0] xvb);
        exp_t x;
        x = {xsa, xsb, xde, xdm, xva, xvb};
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic w, input logic [63:0] e, input logic [63:0] m);
        bus.icode = ic;
        bus.rA    = a;
        bus.rB    = b;
        bus.cnd   = c;
        bus.wb_en = w;
        bus.valE  = e;
        bus.valM  = m;
    endtask

    task automatic step(input string nm, input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic w, input logic [63:0] e, input logic [63:0] m,
                        input logic [3:0] xsa, input logic [3:0] xsb, input logic [3:0] xde,
                        input logic [3:0] xdm, input logic [63:0] xva, input logic [63:0] xvb);
        @(posedge clk);
        #1;
        drive(ic, a, b, c, w, e, m);
        expect_now(nm, xsa, xsb, xde, xdm, xva, xvb);
    endtask

    // Monitor: outputs are combinational, so every pending expectation is compared mid-cycle
    initial begin
        exp_t  x;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {bus.srcA, bus.srcB, bus.dstE, bus.dstM, bus.valA, bus.valB};
                checks++;
                if (act !== x) begin
                    errors++;
                    $display("FAIL %s: got srcA=%h srcB=%h dstE=%h dstM=%h valA=%h valB=%h, want srcA=%h srcB=%h dstE=%h dstM=%h valA=%h valB=%h",
                             nm, act.sa, act.sb, act.de, act.dm, act.va, act.vb,
                             x.sa, x.sb, x.de, x.dm, x.va, x.vb);
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            step($sformatf("reset_reg%0d", i), 4'h6, 4'(i), 4'(i), 0, 0, 0, 0,
                 4'(i), 4'(i), 4'(i), 4'hF, 64'h0, 64'h0);

        step("irmovq_decode", 4'h3, 4'hF, 4'h3, 0, 1, 64'h1234, 64'h0, 4'hF, 4'hF, 4'h3, 4'hF, 64'h0, 64'h0);
        step("irmovq_read",   4'h6, 4'h3, 4'h3, 0, 0, 64'h0, 64'h0, 4'h3, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h1234);
        step("cmov_cnd0",     4'h2, 4'h1, 4'h2, 0, 1, 64'hAA, 64'h0, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        step("cmov_cnd0_rd",  4'h6, 4'h2, 4'h2, 0, 0, 64'h0, 64'h0, 4'h2, 4'h2, 4'h2, 4'hF, 64'h0, 64'h0);
        step("cmov_cnd1",     4'h2, 4'h1, 4'h2, 1, 1, 64'hAA, 64'h0, 4'h1, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0);
        step("cmov_cnd1_rd",  4'h6, 4'h2, 4'h2, 0, 0, 64'h0, 64'h0, 4'h2, 4'h2, 4'h2, 4'hF, 64'hAA, 64'hAA);
        step("popq_rsp",      4'hB, 4'h4, 4'hF, 0, 1, 64'h108, 64'h5000, 4'h4, 4'h4, 4'h4, 4'h4, 64'h0, 64'h0);
        step("popq_rsp_rd",   4'h6, 4'h4, 4'h4, 0, 0, 64'h0, 64'h0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h5000, 64'h5000);
        step("pushq",         4'hA, 4'h7, 4'hF, 0, 0, 64'h0, 64'h0, 4'h7, 4'h4, 4'h4, 4'hF, 64'h0, 64'h5000);
        step("call",          4'h8, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'h5000);
        step("ret",           4'h9, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h5000, 64'h5000);
        step("mrmovq",        4'h5, 4'h6, 4'h3, 0, 0, 64'h0, 64'h0, 4'hF, 4'h3, 4'hF, 4'h6, 64'h0, 64'h1234);
        step("rmmovq",        4'h4, 4'h3, 4'h2, 0, 0, 64'h0, 64'h0, 4'h3, 4'h2, 4'hF, 4'hF, 64'h1234, 64'hAA);
        step("illegal_C",     4'hC, 4'h3, 4'h3, 1, 1, 64'h77, 64'h77, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        step("nop",           4'h1, 4'h3, 4'h3, 1, 1, 64'h77, 64'h77, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        step("jxx",           4'h7, 4'h3, 4'h3, 1, 0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        step("illegal_rd",    4'h6, 4'h3, 4'h4, 0, 0, 64'h0, 64'h0, 4'h3, 4'h4, 4'h4, 4'hF, 64'h1234, 64'h5000);
        step("popq_r8",       4'hB, 4'h8, 4'hF, 0, 1, 64'h100, 64'h77, 4'h4, 4'h4, 4'h4, 4'h8, 64'h5000, 64'h5000);
        step("popq_r8_rd",    4'h6, 4'h8, 4'h4, 0, 0, 64'h0, 64'h0, 4'h8, 4'h4, 4'h4, 4'hF, 64'h77, 64'h100);
        for (int i = 0; i < 3; i++)
            step($sformatf("wb_off_%0d", i), 4'h6, 4'h5, 4'h5, 0, 0, 64'hFFFF, 64'h0,
                 4'h5, 4'h5, 4'h5, 4'hF, 64'h0, 64'h0);
        step("wb_off_after",  4'h6, 4'h5, 4'h5, 0, 0, 64'h0, 64'h0, 4'h5, 4'h5, 4'h5, 4'hF, 64'h0, 64'h0);
        step("same_cycle_old",4'h6, 4'h5, 4'h5, 0, 1, 64'hFFFF, 64'h0, 4'h5, 4'h5, 4'h5, 4'hF, 64'h0, 64'h0);
        step("after_edge_new",4'h6, 4'h5, 4'h3, 0, 0, 64'h0, 64'h0, 4'h5, 4'h3, 4'h3, 4'hF, 64'hFFFF, 64'h1234);

        @(posedge clk);
        #1;
        drive(4'h6, 4'h5, 4'h4, 0, 0, 64'h0, 64'h0);
        #1 rst_n = 1'b0;
        expect_now("async_reset", 4'h5, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0);

        step("reset_wb_blocked", 4'h3, 4'hF, 4'h3, 0, 1, 64'h99, 64'h0, 4'hF, 4'hF, 4'h3, 4'hF, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'h6, 4'h3, 4'h4, 0, 0, 64'h0, 64'h0);
        expect_now("post_reset_rd", 4'h3, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0);
        step("post_reset_r8", 4'h6, 4'h8, 4'h2, 0, 0, 64'h0, 64'h0, 4'h8, 4'h2, 4'h2, 4'hF, 64'h0, 64'h0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- SEQ register-file stage, directly downstream of fetch.
- Consumes icode/rA/rB from fetch and derives srcA/srcB/dstE/dstM.
- Provides valA/valB combinationally to execute.
- Commits valE/valM back into the 15-entry Y86 register file on the rising clock edge.
- Register state is the only storage; the block holds the architectural register file for the whole sequential processor.

Parameters:
DATA_WIDTH, 64, register and operand width
NUM_REGS, 15, architectural registers (IDs 0..14; ID 4'hF = RNONE)
RSP_ID, 4, register ID used as stack pointer
RSP_RESET, 64'd0, reset value of %rsp (all other registers reset to 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
icode  input  4  instruction code from fetch
rA  input  4  register specifier A from fetch (4'hF when absent)
rB  input  4  register specifier B from fetch (4'hF when absent)
cnd  input  1  condition result from execute (cmovXX gating)
wb_en  input  1  commit strobe; writes occur only when high
valE  input  DATA_WIDTH  execute result for E write port
valM  input  DATA_WIDTH  memory result for M write port
srcA  output  4  decoded A read register
srcB  output  4  decoded B read register
dstE  output  4  decoded E write register (after cnd gating)
dstM  output  4  decoded M write register
valA  output  DATA_WIDTH  regfile[srcA], 0 when srcA = 4'hF
valB  output  DATA_WIDTH  regfile[srcB], 0 when srcB = 4'hF

Behaviour:
- Reset (rst_n low, async):
  - All registers clear to 0, except RSP_ID, which loads RSP_RESET.
  - Takes effect immediately, regardless of clk; valA/valB reflect the cleared values in the same delta.
  - No write occurs while rst_n is low, even with wb_en high.
- Decode is purely combinational from icode/rA/rB/cnd.
  - srcA:
    - rA for icode 2 (rrmovq/cmov), 4 (rmmovq), 6 (OPq), A (pushq)
    - RSP_ID for 9 (ret), B (popq)
    - else F
  - srcB:
    - rB for 4, 5 (mrmovq), 6
    - RSP_ID for 8 (call), 9, A, B
    - else F
  - dstE:
    - rB for 3 (irmovq), 6
    - rB for 2 only when cnd = 1, else F
    - RSP_ID for 8, 9, A, B
    - else F
  - dstM:
    - rA for 5, B
    - else F
  - icode 0, 1, 7 and any illegal icode (C..F): all four IDs = F.
- Read latency 0: valA/valB update combinationally whenever srcA/srcB or register contents change.
- Write timing:
  - On rising clk with wb_en = 1: regfile[dstE] <= valE if dstE != F; regfile[dstM] <= valM if dstM != F.
  - New value is visible on valA/valB the cycle after the edge.
  - A same-cycle read returns the old value; no internal bypass.
- Collision: dstE == dstM (popq %rsp):
  - M port wins; valM is written, valE is discarded.
  - This is required for correct popq %rsp semantics.
- Out-of-range IDs:
  - Only ID F means "no register".
  - IDs 0..14 are all valid with NUM_REGS = 15.
  - Writes to F are dropped; reads of F return 0.
- wb_en = 0: register file holds; decode outputs still track inputs.
- Reset asserted between edges aborts nothing pending; there is no multi-cycle operation.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, release -> every register reads 0, including RSP_ID with the default RSP_RESET = 0; assert rst_n = 0 mid-cycle after writes -> valA drops to 0 without a clk edge.
- irmovq $0x1234, %rbx: icode = 3, rA = F, rB = 3, valE = 64'h1234, wb_en = 1, one edge -> dstE = 3, dstM = F; next cycle with icode = 6, rA = 3 -> valA = 64'h1234.
- cmov gating: icode = 2, rA = 1, rB = 2, cnd = 0, valE = 64'hAA -> dstE = F, reg2 unchanged; repeat with cnd = 1 -> dstE = 2, reg2 = 64'hAA after the edge.
- popq %rsp: icode = B, rA = 4, valE = 64'h108, valM = 64'h5000 -> srcA = srcB = dstE = dstM = 4; after the edge reg4 = 64'h5000 (M priority).
- pushq/call/ret decode: icode = A, rA = 7 -> srcA = 7, srcB = 4, dstE = 4, dstM = F; icode = 8 -> srcA = F, srcB = 4, dstE = 4; icode = 9 -> srcA = 4, srcB = 4, dstE = 4.
- wb_en = 0 with icode = 6, rB = 5, valE = 64'hFFFF -> reg5 unchanged after 3 edges; a same-cycle read of the register being written returns the old value until the edge.
